// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the core instruction port, core data port and host loader.
// Grants are combinational; a 2-bit tag routes each read's data back to its requester.
module mem_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 16,
    parameter int MAX_HOST_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic [DW-1:0] i_rdata,
    output logic          i_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic [DW-1:0] h_rdata,
    output logic          h_rvalid,
    output logic          hold_cpu,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    output logic          m_oe,
    input  logic [DW-1:0] m_rdata
);

    localparam int CW = $clog2(MAX_HOST_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_HOST_BURST - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOST = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2,
        TAG_H    = 2'd3
    } tag_e;

    state_e        state_q, state_d;
    logic          alt_q, alt_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          skip_host_q, skip_host_d;
    tag_e          tag_q, tag_d;

    // Arbitration, next-state, memory drive and read-tag capture.
    always_comb begin
        state_d     = state_q;
        alt_d       = alt_q;
        burst_cnt_d = burst_cnt_q;
        skip_host_d = skip_host_q;
        tag_d       = TAG_NONE;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        h_gnt       = 1'b0;
        hold_cpu    = 1'b0;
        m_addr      = {AW{1'b0}};
        m_wdata     = {DW{1'b0}};
        m_we        = 1'b0;
        m_oe        = 1'b0;

        case (state_q)
            ST_RUN: begin
                // After a forced host exit, h_req is ignored for one cycle.
                if (h_req && !skip_host_q) begin
                    state_d = ST_HOST;
                end else begin
                    if (i_req && d_req) begin
                        i_gnt = alt_q;
                        d_gnt = !alt_q;
                    end else begin
                        i_gnt = i_req;
                        d_gnt = d_req;
                    end
                    if (d_gnt && i_req) begin
                        alt_d = 1'b1;
                    end else if (i_gnt) begin
                        alt_d = 1'b0;
                    end else begin
                        alt_d = alt_q;
                    end
                end
                skip_host_d = 1'b0;
                burst_cnt_d = {CW{1'b0}};
                hold_cpu    = (i_req && !i_gnt) || (d_req && !d_gnt);
            end
            ST_HOST: begin
                h_gnt    = h_req;
                hold_cpu = 1'b1;
                if (h_req) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d     = ST_RUN;
                        burst_cnt_d = {CW{1'b0}};
                        skip_host_d = 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d     = ST_RUN;
                    burst_cnt_d = {CW{1'b0}};
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            i_gnt    = 1'b0;
            d_gnt    = 1'b0;
            h_gnt    = 1'b0;
            hold_cpu = 1'b0;
        end else begin
            hold_cpu = hold_cpu;
        end

        if (h_gnt) begin
            m_addr  = h_addr;
            m_wdata = h_wdata;
            m_we    = h_we;
            m_oe    = !h_we;
            tag_d   = h_we ? TAG_NONE : TAG_H;
        end else if (d_gnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_we    = d_we;
            m_oe    = !d_we;
            tag_d   = d_we ? TAG_NONE : TAG_D;
        end else if (i_gnt) begin
            m_addr  = i_addr;
            m_oe    = 1'b1;
            tag_d   = TAG_I;
        end else begin
            tag_d   = TAG_NONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            alt_q       <= 1'b0;
            burst_cnt_q <= {CW{1'b0}};
            skip_host_q <= 1'b0;
            tag_q       <= TAG_NONE;
        end else begin
            state_q     <= state_d;
            alt_q       <= alt_d;
            burst_cnt_q <= burst_cnt_d;
            skip_host_q <= skip_host_d;
            tag_q       <= tag_d;
        end
    end

    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign h_rdata  = m_rdata;
    assign i_rvalid = (tag_q == TAG_I) && !rst;
    assign d_rvalid = (tag_q == TAG_D) && !rst;
    assign h_rvalid = (tag_q == TAG_H) && !rst;

endmodule
